// File: rtl/muldiv_unit.sv
// Iterative unsigned n-bit multiply (shift-add) / divide (restoring), one bit per cycle.
// Latency: busy for exactly n cycles after the accepting edge, then a one-cycle done pulse.
// No backpressure: start is ignored while busy; kill aborts to IDLE; HI/LO only change on completion.
module muldiv_unit #(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op,
    input  logic         kill,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] HI,
    output logic [n-1:0] LO
);

    localparam int CW = (n > 1) ? $clog2(n) : 1;
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          op_q;     // 0 = multiply, 1 = divide
    logic [n-1:0]  opnd;     // multiplicand (mul) or divisor (div)
    logic [n-1:0]  acc_hi;   // upper product half (mul) or partial remainder (div)
    logic [n-1:0]  acc_lo;   // multiplier being consumed (mul) or dividend/quotient (div)

    logic [n:0]    sum;      // carry-preserving add for shift-add multiply
    logic [n:0]    rem_sh;   // remainder after the left shift, one bit wider than rem
    logic [n:0]    diff;     // trial subtraction; bit n set means negative
    logic [n-1:0]  nxt_hi;
    logic [n-1:0]  nxt_lo;

    // One iteration of the selected algorithm, computed from the current accumulator.
    // The shifted remainder is always below 2*divisor, so diff[n] is a reliable sign bit;
    // with a zero divisor the trial never fails, giving all-ones quotient and remainder = A.
    always_comb begin
        sum    = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {n{1'b0}})};
        rem_sh = {acc_hi, acc_lo[n-1]};
        diff   = rem_sh - {1'b0, opnd};
        nxt_hi = acc_hi;
        nxt_lo = acc_lo;
        if (!op_q) begin
            nxt_hi = sum[n:1];
            nxt_lo = {sum[0], acc_lo[n-1:1]};
        end else if (!diff[n]) begin
            nxt_hi = diff[n-1:0];
            nxt_lo = {acc_lo[n-2:0], 1'b1};
        end else begin
            nxt_hi = rem_sh[n-1:0];
            nxt_lo = {acc_lo[n-2:0], 1'b0};
        end
    end

    // Control FSM with registered busy/done and result registers updated only on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            count  <= '0;
            op_q   <= 1'b0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else if (kill) begin
            // Flush wins over everything, including a same-cycle start.
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_q   <= op;
                        opnd   <= op ? B : A;
                        acc_hi <= '0;
                        acc_lo <= op ? A : B;
                        count  <= '0;
                        state  <= S_BUSY;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                S_BUSY: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        HI    <= nxt_hi;
                        LO    <= nxt_lo;
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed operations push expected {HI,LO}.
// A negedge monitor pops and compares on every done pulse.
// Handshake timing, start-while-busy, kill and async reset are checked inline.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op;
    logic        kill;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] hi;
    logic [15:0] lo;

    int          n_cmp;
    int          n_bad;
    int          cyc;
    logic [31:0] exp_q[$];

    muldiv_unit #(.n(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .op   (op),
        .kill (kill),
        .A    (a),
        .B    (b),
        .busy (busy),
        .done (done),
        .HI   (hi),
        .LO   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("result_hi", {16'h0, hi}, {16'h0, e[31:16]});
                chk("result_lo", {16'h0, lo}, {16'h0, e[15:0]});
            end
        end
    end

    // Drive a one-cycle start; call at posedge+1 or in the done cycle for back-to-back.
    task automatic issue(input logic o, input logic [15:0] x, input logic [15:0] y,
                         input bit push, input logic [31:0] e);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done, counting busy cycles seen on the way; returns at a negedge.
    task automatic wait_done(output int bc);
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) break;
            if (busy) bc++;
        end
        chk("done_seen", {31'h0, done}, 32'd1);
    endtask

    typedef struct {
        logic        o;
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] e;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int t0;
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        kill  = 1'b0;
        a     = '0;
        b     = '0;

        // Hand-computed directed vectors.
        vecs[0] = '{1'b0, 16'h1234, 16'h5678, {16'h0626, 16'h0060}};
        vecs[1] = '{1'b1, 16'hFFFF, 16'h0001, {16'h0000, 16'hFFFF}};
        vecs[2] = '{1'b1, 16'h0005, 16'h0009, {16'h0005, 16'h0000}};
        vecs[3] = '{1'b1, 16'hFFFF, 16'hFFFF, {16'h0000, 16'h0001}};
        vecs[4] = '{1'b1, 16'h8000, 16'h0003, {16'h0002, 16'h2AAA}};
        vecs[5] = '{1'b1, 16'hFFFF, 16'h8001, {16'h7FFE, 16'h0001}};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset.
        repeat (5) begin
            @(negedge clk);
            chk("idle_busy", {31'h0, busy}, 32'd0);
            chk("idle_done", {31'h0, done}, 32'd0);
            chk("idle_hi",   {16'h0, hi},   32'h0);
            chk("idle_lo",   {16'h0, lo},   32'h0);
        end

        // Full-scale multiply, latency and hold.
        @(posedge clk); #1;
        issue(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, {16'hFFFE, 16'h0001});
        wait_done(bc);
        chk("mul_busy_cycles", 32'(bc), 32'd16);
        @(negedge clk);
        chk("done_pulse_width", {31'h0, done}, 32'd0);
        repeat (3) @(negedge clk);
        chk("hold_hi", {16'h0, hi}, 32'h0000FFFE);
        chk("hold_lo", {16'h0, lo}, 32'h00000001);

        // Divide, then back-to-back divide by zero started in the done cycle.
        @(posedge clk); #1;
        issue(1'b1, 16'd100, 16'd7, 1'b1, {16'h0002, 16'h000E});
        wait_done(bc);
        chk("div_busy_cycles", 32'(bc), 32'd16);
        t0 = cyc;
        issue(1'b1, 16'h1234, 16'h0000, 1'b1, {16'h1234, 16'hFFFF});
        wait_done(bc);
        chk("b2b_busy_cycles", 32'(bc), 32'd16);
        chk("b2b_done_gap", 32'(cyc - t0), 32'd17);

        // start while busy is ignored.
        @(posedge clk); #1;
        issue(1'b0, 16'd3, 16'd5, 1'b1, {16'h0000, 16'h000F});
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; a = 16'd9; b = 16'd9;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(bc);
        chk("ignored_start_busy", 32'(bc), 32'd12);
        repeat (3) @(negedge clk);
        chk("no_restart_busy", {31'h0, busy}, 32'd0);

        // Kill mid-divide leaves HI/LO from the previous result and produces no done.
        @(posedge clk); #1;
        issue(1'b0, 16'h0010, 16'h0010, 1'b1, {16'h0000, 16'h0100});
        wait_done(bc);
        @(posedge clk); #1;
        issue(1'b1, 16'd50, 16'd5, 1'b0, 32'h0);
        repeat (7) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        chk("kill_busy", {31'h0, busy}, 32'd0);
        repeat (20) @(negedge clk);
        chk("kill_busy_later", {31'h0, busy}, 32'd0);
        chk("kill_hi", {16'h0, hi}, 32'h00000000);
        chk("kill_lo", {16'h0, lo}, 32'h00000100);

        // Directed vector table.
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            issue(vecs[i].o, vecs[i].x, vecs[i].y, 1'b1, vecs[i].e);
            wait_done(bc);
            chk("vec_busy_cycles", 32'(bc), 32'd16);
        end

        // Asynchronous reset in the middle of a multiply.
        @(posedge clk); #1;
        issue(1'b0, 16'h00FF, 16'h0101, 1'b0, 32'h0);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'h0, busy}, 32'd0);
        chk("arst_done", {31'h0, done}, 32'd0);
        chk("arst_hi",   {16'h0, hi},   32'h0);
        chk("arst_lo",   {16'h0, lo},   32'h0);
        #1 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_busy", {31'h0, busy}, 32'd0);
            chk("post_rst_done", {31'h0, done}, 32'd0);
        end

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
